// File: rtl/uart_tx_mmio.sv
// rtl/uart_tx_mmio.sv - memory-mapped UART transmitter with 8-entry byte FIFO
// Optional even parity bit between data bit 7 and stop when UART_TX_PARITY_EN is defined.
module uart_tx_mmio #(
    parameter int CLK_DIV = 434
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] io_a,
    input  logic        wio,
    input  logic [31:0] d_t_io,
    output logic [31:0] d_f_io,
    output logic        txd,
    output logic        tx_busy
);

    localparam logic [15:0] RELOAD = 16'(CLK_DIV - 1);

`ifdef UART_TX_PARITY_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
    typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif

    state_t      state;
    logic [7:0]  fifo_mem [8];
    logic [2:0]  wr_ptr;
    logic [2:0]  rd_ptr;
    logic [3:0]  count;
    logic        overflow;
    logic [15:0] bit_cnt;
    logic [2:0]  bit_idx;
    logic [7:0]  shift;
`ifdef UART_TX_PARITY_EN
    logic        parity_bit;
`endif

    logic sel;
    logic push_req;
    logic status_wr;
    logic pop;
    logic push_ok;
    logic full;
    logic empty;
    logic unused_bits;

    assign sel       = (io_a[31:28] == 4'hC);
    assign push_req  = wio && sel && !io_a[2];
    assign status_wr = wio && sel && io_a[2];
    assign full      = (count == 4'd8);
    assign empty     = (count == 4'd0);
    assign pop       = (state == IDLE) && !empty;
    // A full FIFO still accepts a push when the shifter drains an entry on the same edge.
    assign push_ok   = push_req && (!full || pop);

    assign tx_busy     = (state != IDLE) || !empty;
    assign d_f_io      = (sel && io_a[2]) ? {28'b0, overflow, tx_busy, full, empty} : 32'b0;
    assign unused_bits = ^{io_a[27:3], io_a[1:0], d_t_io[31:8]};

    always_ff @(posedge clk) begin
        if (!rst && push_ok) begin
            fifo_mem[wr_ptr] <= d_t_io[7:0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr   <= 3'd0;
            rd_ptr   <= 3'd0;
            count    <= 4'd0;
            overflow <= 1'b0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + 3'd1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 3'd1;
            end
            case ({push_ok, pop})
                2'b10:   count <= count + 4'd1;
                2'b01:   count <= count - 4'd1;
                default: count <= count;
            endcase
            if (status_wr) begin
                overflow <= 1'b0;
            end else if (push_req && !push_ok) begin
                overflow <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            txd     <= 1'b1;
            bit_cnt <= 16'd0;
            bit_idx <= 3'd0;
            shift   <= 8'd0;
`ifdef UART_TX_PARITY_EN
            parity_bit <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (!empty) begin
                        shift   <= fifo_mem[rd_ptr];
`ifdef UART_TX_PARITY_EN
                        parity_bit <= ^fifo_mem[rd_ptr];
`endif
                        txd     <= 1'b0;
                        bit_cnt <= RELOAD;
                        state   <= START;
                    end
                end
                START: begin
                    if (bit_cnt == 16'd0) begin
                        txd     <= shift[0];
                        shift   <= {1'b0, shift[7:1]};
                        bit_idx <= 3'd0;
                        bit_cnt <= RELOAD;
                        state   <= DATA;
                    end else begin
                        bit_cnt <= bit_cnt - 16'd1;
                    end
                end
                DATA: begin
                    if (bit_cnt == 16'd0) begin
                        bit_cnt <= RELOAD;
                        if (bit_idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                            txd   <= parity_bit;
                            state <= PARITY;
`else
                            txd   <= 1'b1;
                            state <= STOP;
`endif
                        end else begin
                            txd     <= shift[0];
                            shift   <= {1'b0, shift[7:1]};
                            bit_idx <= bit_idx + 3'd1;
                        end
                    end else begin
                        bit_cnt <= bit_cnt - 16'd1;
                    end
                end
`ifdef UART_TX_PARITY_EN
                PARITY: begin
                    if (bit_cnt == 16'd0) begin
                        txd     <= 1'b1;
                        bit_cnt <= RELOAD;
                        state   <= STOP;
                    end else begin
                        bit_cnt <= bit_cnt - 16'd1;
                    end
                end
`endif
                STOP: begin
                    // Returning to IDLE lets the next pop happen on the very next edge.
                    if (bit_cnt == 16'd0) begin
                        state <= IDLE;
                    end else begin
                        bit_cnt <= bit_cnt - 16'd1;
                    end
                end
                default: begin
                    state <= IDLE;
                    txd   <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: doc/uart_tx_mmio.md
UART_TX_MMIO -- requirements
Module: uart_tx_mmio

Interface
REQ-001 SHALL have parameter CLK_DIV, default 434: clock cycles per serial bit; legal range 2..65535.
REQ-002 SHALL have port clk, input, 1: sole clock; all state updates on the rising edge.
REQ-003 SHALL have port rst, input, 1: reset, synchronous, active-high.
REQ-004 SHALL have port io_a, input, 32: CPU store/load address.
REQ-005 SHALL have port wio, input, 1: CPU store strobe, valid for one cycle per store.
REQ-006 SHALL have port d_t_io, input, 32: CPU store data.
REQ-007 SHALL have port d_f_io, output, 32: combinational read data.
REQ-008 SHALL have port txd, output, 1: serial line, idle high.
REQ-009 SHALL have port tx_busy, output, 1: high while the shifter is not IDLE or the FIFO is non-empty.

Function
REQ-010 SHALL select the block when io_a[31:28]==4'hC; io_a[2]==0 is DATA, io_a[2]==1 is STATUS.
REQ-011 SHALL push d_t_io[7:0] into an 8-entry FIFO on a clock edge with wio=1, block selected and DATA offset; d_t_io[31:8] is ignored.
REQ-012 SHALL use 3-bit read/write pointers that wrap 7->0, plus a 4-bit count in the range 0..8.
REQ-013 SHALL drop a push when count==8 with no pop on the same edge, and set sticky overflow.
REQ-014 SHALL accept the push on a simultaneous push and pop with count==8; count stays 8.
REQ-015 SHALL clear overflow on a store to STATUS; data bits of that store are ignored.
REQ-016 SHALL drive d_f_io = {28'b0, overflow, tx_busy, full, empty} when STATUS is selected, otherwise 32'b0.
REQ-017 SHALL implement FSM states IDLE, START, DATA, PARITY, STOP.
REQ-018 In IDLE with the FIFO non-empty: on that edge, SHALL pop one byte, load the shifter, go to START and set txd to 0.
REQ-019 SHALL hold each state's txd value for exactly CLK_DIV cycles, timed by a 16-bit down-counter reloaded with CLK_DIV-1.
REQ-020 DATA SHALL send 8 bits LSB first with a 3-bit bit index; after bit 7 it goes to PARITY if enabled, otherwise to STOP.
REQ-021 STOP SHALL drive txd=1; on expiry it goes to IDLE, and the next pop may occur on the following edge, giving back-to-back frames with no extra idle bit.
REQ-022 Latency: a store at edge E into an empty FIFO while IDLE SHALL cause txd to fall after edge E+1.
REQ-023 Frame length SHALL be 10*CLK_DIV cycles, or 11*CLK_DIV with parity.
REQ-024 A read SHALL have no side effects.

Reset
REQ-025 With rst=1 at an edge, SHALL force state IDLE, txd=1, pointers=0, count=0, overflow=0, counter=0, bit index=0.
REQ-026 Reset mid-frame SHALL abort the frame, return txd high after that edge, and discard FIFO contents.
REQ-027 rst SHALL take priority over a simultaneous wio.
REQ-028 Outputs after reset: txd=1, tx_busy=0, and d_f_io at STATUS = 32'h1.

Configuration
REQ-029 Macro UART_TX_PARITY_EN SHALL, when defined, include the PARITY state, which sends even parity (XOR of the 8 data bits) between bit 7 and STOP.
REQ-030 Without UART_TX_PARITY_EN, the PARITY state and its logic SHALL be absent, and DATA SHALL go directly to STOP.

Verification (bench CLK_DIV=4)
REQ-031 Single byte: reset, store 32'h00000041 to 32'hC0000000 -> txd low after the next edge, then bits 1,0,0,0,0,0,1,0, then stop high; 40 cycles total (44 with parity, parity bit 0).
REQ-032 Overflow: store 9 bytes back-to-back while the line is busy before the first pop -> STATUS reads overflow=1, full=1; the dropped byte never appears; a store to 32'hC0000004 clears overflow.
REQ-033 Back-to-back frames: store 8'h55 then 8'hAA -> the second start bit immediately follows the first stop bit; tx_busy falls only after the second stop bit.
REQ-034 Wrap: send 12 bytes in batches of 4 -> all 12 bytes are serialized in order across the pointer wrap.
REQ-035 Reset mid-frame: assert rst during DATA bit 3 -> txd=1 after that edge; STATUS reads 32'h1; no residual frame follows.
REQ-036 Decode: store to 32'h80000000 -> no push; empty stays 1, txd stays 1.
